// File: rtl/flip_flop_fifo_pkg.sv
// Shared sizing helpers for the level/flag flip-flop FIFO and its wrapping pointers.
package flip_flop_fifo_pkg;

   function automatic int unsigned level_width(input int unsigned d);
      return $clog2(d + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned d);
      return (d < 2) ? 1 : $clog2(d);
   endfunction

   // Default almost_full threshold: two entries short of full
   function automatic int unsigned default_almost_full(input int unsigned d);
      return (d < 2) ? 0 : d - 2;
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-depth pointer with a circle bit that toggles on every wrap; works for any depth.
module fifo_wrap_ptr
   import flip_flop_fifo_pkg::*;
#(
   parameter int unsigned depth = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inc,
   output logic [ptr_width(depth)-1:0] ptr,
   output logic                        circle
);

   localparam int unsigned ptr_w = ptr_width(depth);
   localparam logic [ptr_w-1:0] last = ptr_w'(depth - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr    <= '0;
         circle <= 1'b0;
      end else if (inc) begin
         if (ptr == last) begin
            ptr    <= '0;
            circle <= ~circle;
         end else begin
            ptr <= ptr + ptr_w'(1);
         end
      end
   end

endmodule

// File: rtl/flip_flop_fifo_level_flags.sv
// Any-depth flip-flop FIFO with registered level, almost flags and sticky error flags.
// Define FLIP_FLOP_FIFO_LEVEL_FLAGS_BYPASS_EN for fall-through when empty.
module flip_flop_fifo_level_flags
   import flip_flop_fifo_pkg::*;
#(
   parameter int unsigned width              = 8,
   parameter int unsigned depth              = 10,
   parameter int unsigned almost_empty_level = 1,
   parameter int unsigned almost_full_level  = default_almost_full(depth)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [width-1:0]              write_data,
   input  logic                          clear_errors,
   output logic [width-1:0]              read_data,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [level_width(depth)-1:0] level,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int unsigned ptr_w = ptr_width(depth);
   localparam int unsigned lvl_w = level_width(depth);
   localparam logic [lvl_w-1:0] ae_lvl = lvl_w'(almost_empty_level);
   localparam logic [lvl_w-1:0] af_lvl = lvl_w'(almost_full_level);

   logic [width-1:0] mem [depth];
   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   logic             wr_circle;
   logic             rd_circle;
   logic             push_ok;
   logic             pop_ok;
   logic             pass_c;
   logic             wr_inc;
   logic             rd_inc;

   fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
      .clk    (clk),
      .rst    (rst),
      .inc    (wr_inc),
      .ptr    (wr_ptr),
      .circle (wr_circle)
   );

   fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
      .clk    (clk),
      .rst    (rst),
      .inc    (rd_inc),
      .ptr    (rd_ptr),
      .circle (rd_circle)
   );

   // Equal pointers mean empty or full; the circle bits tell which
   assign empty        = (wr_ptr == rd_ptr) && (wr_circle == rd_circle);
   assign full         = (wr_ptr == rd_ptr) && (wr_circle != rd_circle);
   assign almost_empty = (level <= ae_lvl);
   assign almost_full  = (level >= af_lvl);

   // Accept/drop decisions; a pass-through neither stores nor moves pointers
   always_comb begin
      pop_ok = pop & ~empty;
      pass_c = 1'b0;
`ifdef FLIP_FLOP_FIFO_LEVEL_FLAGS_BYPASS_EN
      pop_ok = pop & (~empty | push);
      pass_c = empty & push & pop;
`endif
      push_ok = push & (~full | pop_ok);
      wr_inc  = push_ok & ~pass_c;
      rd_inc  = pop_ok & ~pass_c;
   end

`ifdef FLIP_FLOP_FIFO_LEVEL_FLAGS_BYPASS_EN
   assign read_data = (empty & push) ? write_data : mem[rd_ptr];
`else
   assign read_data = mem[rd_ptr];
`endif

   always_ff @(posedge clk) begin
      if (wr_inc) begin
         mem[wr_ptr] <= write_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= '0;
      end else if (push_ok & ~pop_ok) begin
         level <= level + lvl_w'(1);
      end else if (pop_ok & ~push_ok) begin
         level <= level - lvl_w'(1);
      end
   end

   // Sticky misuse flags; clear wins over a same-cycle set
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear_errors) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push & ~push_ok) overflow  <= 1'b1;
         if (pop & ~pop_ok)   underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flip_flop_fifo_level_flags.sv
// Table-driven bench with a data scoreboard for flip_flop_fifo_level_flags (depth 10 and 7).
module tb_flip_flop_fifo_level_flags;

   logic       clk = 1'b0;
   logic       rst;
   logic       push, pop, clr;
   logic [7:0] wdata, rdata;
   logic       empty, full, ae, af, ovf, unf;
   logic [3:0] level;

   logic       push7, pop7, clr7;
   logic [7:0] wdata7, rdata7;
   logic       empty7, full7, ae7, af7, ovf7, unf7;
   logic [2:0] level7;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic       push, pop, clr;
      logic [7:0] wdata;
      int         level;
      logic       empty, full, ae, af, ovf, unf;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   flip_flop_fifo_level_flags u_dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .write_data(wdata),
      .clear_errors(clr), .read_data(rdata), .empty(empty), .full(full),
      .almost_empty(ae), .almost_full(af), .level(level),
      .overflow(ovf), .underflow(unf)
   );

   flip_flop_fifo_level_flags #(.depth(7)) u_dut7 (
      .clk(clk), .rst(rst), .push(push7), .pop(pop7), .write_data(wdata7),
      .clear_errors(clr7), .read_data(rdata7), .empty(empty7), .full(full7),
      .almost_empty(ae7), .almost_full(af7), .level(level7),
      .overflow(ovf7), .underflow(unf7)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input string n, input logic pu, input logic po, input logic cl,
                               input logic [7:0] wd, input int lv, input logic em, input logic fu,
                               input logic a_e, input logic a_f, input logic ov, input logic un);
      vec_t v;
      v.name = n; v.push = pu; v.pop = po; v.clr = cl; v.wdata = wd; v.level = lv;
      v.empty = em; v.full = fu; v.ae = a_e; v.af = a_f; v.ovf = ov; v.unf = un;
      vecs.push_back(v);
   endfunction

   initial begin
      vec_t       v;
      logic [7:0] exp_d;
      bit         pop_eff, pass;
      int         pushes, pops;
      logic [7:0] d7;
      logic [7:0] q7[$];

      rst = 1'b1; push = 0; pop = 0; clr = 0; wdata = 0;
      push7 = 0; pop7 = 0; clr7 = 0; wdata7 = 0;

      // Fill, overflow, full push+pop, drain, underflow, clears, empty push+pop
      for (int k = 1; k <= 10; k++)
         add("fill", 1, 0, 0, 8'(k), k, 0, k == 10, k <= 1, k >= 8, 0, 0);
      add("ovf", 1, 0, 0, 8'hFF, 10, 0, 1, 0, 1, 1, 0);
      add("full_pp", 1, 1, 0, 8'h55, 10, 0, 1, 0, 1, 1, 0);
      for (int k = 1; k <= 10; k++)
         add("drain", 0, 1, 0, 8'h00, 10 - k, k == 10, 0, (10 - k) <= 1, (10 - k) >= 8, 1, 0);
      add("unf", 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 1);
      add("clr", 0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0);
      add("clr_pri", 0, 1, 1, 8'h00, 0, 1, 0, 1, 0, 0, 0);
`ifdef FLIP_FLOP_FIFO_LEVEL_FLAGS_BYPASS_EN
      add("byp", 1, 1, 0, 8'hA5, 0, 1, 0, 1, 0, 0, 0);
`else
      add("nobyp", 1, 1, 0, 8'hA5, 1, 0, 0, 1, 0, 0, 1);
      add("nobyp_drain", 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 1);
`endif

      #12 rst = 1'b0;
      @(posedge clk); #1;
      chk("rst level", level, 0);
      chk("rst empty", empty, 1);
      chk("rst full", full, 0);
      chk("rst ae", ae, 1);
      chk("rst af", af, 0);
      chk("rst ovf", ovf, 0);
      chk("rst unf", unf, 0);
      chk("rst empty7", empty7, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         push = v.push; pop = v.pop; clr = v.clr; wdata = v.wdata;
         #1;
         pop_eff = v.pop && (sb.size() > 0);
         pass    = 1'b0;
`ifdef FLIP_FLOP_FIFO_LEVEL_FLAGS_BYPASS_EN
         pass = v.pop && v.push && (sb.size() == 0);
`endif
         if (pop_eff) begin
            exp_d = sb.pop_front();
            chk($sformatf("%s[%0d] rdata", v.name, i), rdata, exp_d);
         end else if (pass) begin
            chk($sformatf("%s[%0d] rdata", v.name, i), rdata, v.wdata);
         end
         if (v.push && !pass && (sb.size() < 10))
            sb.push_back(v.wdata);
         @(posedge clk); #1;
         chk($sformatf("%s[%0d] level", v.name, i), level, v.level);
         chk($sformatf("%s[%0d] empty", v.name, i), empty, v.empty);
         chk($sformatf("%s[%0d] full", v.name, i), full, v.full);
         chk($sformatf("%s[%0d] ae", v.name, i), ae, v.ae);
         chk($sformatf("%s[%0d] af", v.name, i), af, v.af);
         chk($sformatf("%s[%0d] ovf", v.name, i), ovf, v.ovf);
         chk($sformatf("%s[%0d] unf", v.name, i), unf, v.unf);
      end
      push = 0; pop = 0; clr = 0;

      // Asynchronous reset mid-operation discards content before any edge
      for (int k = 0; k < 3; k++) begin
         push = 1; wdata = 8'(8'h30 + k);
         @(posedge clk); #1;
      end
      push = 0;
      chk("pre_rst level", level, 3);
      #1 rst = 1'b1;
      #1;
      chk("async_rst level", level, 0);
      chk("async_rst empty", empty, 1);
      #1 rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      chk("post_rst level", level, 0);

      // One-cycle write-to-read latency from empty
      push = 1; wdata = 8'h77;
      @(posedge clk); #1;
      push = 0;
      chk("latency rdata", rdata, 8'h77);
      chk("latency empty", empty, 0);
      pop = 1;
      @(posedge clk); #1;
      pop = 0;
      chk("latency drain empty", empty, 1);

      // Wrap-around on depth 7 with alternating push/pop
      pushes = 0; pops = 0; d7 = 8'h10;
      for (int c = 0; c < 25; c++) begin
         push7 = (c % 2 == 0);
         pop7  = (c % 2 == 1);
         wdata7 = d7;
         #1;
         if (pop7) begin
            exp_d = q7.pop_front();
            chk($sformatf("wrap[%0d] rdata", c), rdata7, exp_d);
            pops++;
         end else begin
            q7.push_back(d7);
            d7 = d7 + 8'd1;
            pushes++;
         end
         @(posedge clk); #1;
         chk($sformatf("wrap[%0d] level", c), level7, 32'(pushes - pops));
         chk($sformatf("wrap[%0d] wr_ptr", c), u_dut7.wr_ptr, 32'(pushes % 7));
         chk($sformatf("wrap[%0d] wr_circle", c), u_dut7.wr_circle, 32'((pushes / 7) % 2));
         chk($sformatf("wrap[%0d] rd_circle", c), u_dut7.rd_circle, 32'((pops / 7) % 2));
      end
      push7 = 0; pop7 = 0;
      chk("wrap ovf", ovf7, 0);
      chk("wrap unf", unf7, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
